ins_fetch_dec: RTL and testbench

Upstream fetch/decode stage for the RV32I execution units. It fetches one 32-bit instruction word from instruction memory over a req/ack handshake and splits it into opcode, funct3, funct7, rs1, rs2 and rd fields. It then issues a one-cycle `exec_op` strobe to the parallel InsExec_* units. It owns the PC, advancing it by 4 or loading a redirect returned by the exec units in the strobe cycle.

---
 rtl/ins_fetch_dec_pkg.sv | 42 ++++
 rtl/ins_fetch_dec_field_split.sv | 24 ++
 rtl/ins_fetch_dec.sv | 176 +++++++++++++++++
 tb/tb_ins_fetch_dec.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_fetch_dec_pkg.sv
// Types and constants shared by the RV32I fetch/decode stage and the exec units.
package ins_fetch_dec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'd2;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'd3;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] op;
  } ins_fields_t;

  // Only the 32-bit encoding space (low bits 2'b11) is executable here.
  function automatic logic is_32bit_enc(input logic [1:0] low_bits);
    return low_bits == 2'b11;
  endfunction

endpackage

// File: rtl/ins_fetch_dec_field_split.sv
// Combinational split of an RV32I instruction word into its fixed-position fields.
module ins_field_split
  import ins_fetch_dec_pkg::*;
(
  input  logic [31:0] ins,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);

  ins_fields_t fields;

  assign fields = ins;
  assign op     = fields.op;
  assign funct3 = fields.funct3;
  assign funct7 = fields.funct7;
  assign rs1    = fields.rs1;
  assign rs2    = fields.rs2;
  assign rd     = fields.rd;

endmodule

// File: rtl/ins_fetch_dec.sv
// RV32I fetch/decode stage: fetches one word, issues exec_op, owns the PC.
//   state    | meaning
//   ST_IDLE  | waiting for run
//   ST_FETCH | mem_req high until mem_ack or timeout
//   ST_EXEC  | exec_op strobe, next pc chosen
//   ST_NEXT  | retire pulse, instret bump
//   ST_FAULT | sticky fault, wait for fault_clr
module ins_fetch_dec
  import ins_fetch_dec_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        fault_clr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        pc_w_op,
  input  logic [31:0] pc_w_val,
  output logic        exec_op,
  output logic [6:0]  ins_dec_op,
  output logic [2:0]  ins_dec_funct3,
  output logic [6:0]  ins_dec_funct7,
  output logic [4:0]  reg_rs1,
  output logic [4:0]  reg_rs2,
  output logic [4:0]  reg_rd,
  output logic [31:0] pc,
  output logic        retire,
  output logic [31:0] instret,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_pc
);

  localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] instret_q, instret_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        mem_req_q, mem_req_d;
  logic        exec_op_q, exec_op_d;
  logic        retire_q, retire_d;
  logic        fault_q, fault_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ins_d        = ins_q;
    cnt_d        = cnt_q;
    instret_d    = instret_q;
    fault_code_d = fault_code_q;
    fault_pc_d   = fault_pc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          if (pc_q[1:0] != 2'b00) begin
            state_d      = ST_FAULT;
            fault_code_d = FAULT_MISALIGN;
            fault_pc_d   = pc_q;
          end else begin
            state_d = ST_FETCH;
            cnt_d   = '0;
          end
        end
      end
      ST_FETCH: begin
        // An ack in the last allowed cycle still wins over the timeout.
        if (mem_ack) begin
          ins_d   = mem_rdata;
          state_d = ST_EXEC;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          state_d      = ST_FAULT;
          fault_code_d = FAULT_TIMEOUT;
          fault_pc_d   = pc_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_EXEC: begin
        if (!is_32bit_enc(ins_q[1:0])) begin
          state_d      = ST_FAULT;
          fault_code_d = FAULT_ILLEGAL;
          fault_pc_d   = pc_q;
        end else begin
          pc_d    = pc_w_op ? pc_w_val : pc_q + 32'd4;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        instret_d = instret_q + 32'd1;
        if (!run) begin
          state_d = ST_IDLE;
        end else if (pc_q[1:0] != 2'b00) begin
          state_d      = ST_FAULT;
          fault_code_d = FAULT_MISALIGN;
          fault_pc_d   = pc_q;
        end else begin
          state_d = ST_FETCH;
          cnt_d   = '0;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d      = ST_IDLE;
          fault_code_d = FAULT_NONE;
          fault_pc_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are registered so they line up exactly with the state they describe.
    mem_req_d = (state_d == ST_FETCH);
    exec_op_d = (state_d == ST_EXEC) && is_32bit_enc(ins_d[1:0]);
    retire_d  = (state_d == ST_NEXT);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      ins_q        <= '0;
      cnt_q        <= '0;
      instret_q    <= '0;
      fault_code_q <= FAULT_NONE;
      fault_pc_q   <= '0;
      mem_req_q    <= 1'b0;
      exec_op_q    <= 1'b0;
      retire_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ins_q        <= ins_d;
      cnt_q        <= cnt_d;
      instret_q    <= instret_d;
      fault_code_q <= fault_code_d;
      fault_pc_q   <= fault_pc_d;
      mem_req_q    <= mem_req_d;
      exec_op_q    <= exec_op_d;
      retire_q     <= retire_d;
      fault_q      <= fault_d;
    end
  end

  ins_field_split u_field_split (
    .ins    (ins_q),
    .op     (ins_dec_op),
    .funct3 (ins_dec_funct3),
    .funct7 (ins_dec_funct7),
    .rs1    (reg_rs1),
    .rs2    (reg_rs2),
    .rd     (reg_rd)
  );

  assign mem_req    = mem_req_q;
  assign mem_addr   = pc_q;
  assign pc         = pc_q;
  assign exec_op    = exec_op_q;
  assign retire     = retire_q;
  assign instret    = instret_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign fault_pc   = fault_pc_q;

endmodule

// File: tb/tb_ins_fetch_dec.sv
// Bench for ins_fetch_dec: three instances (default, TIMEOUT=4, wrap start with timeout off).
module tb_ins_fetch_dec;

  logic        clk = 1'b0;
  logic [2:0]  rst_n_v;
  logic        run, fault_clr, mem_ack, pc_w_op;
  logic [31:0] mem_rdata, pc_w_val;

  logic        mem_req_w[3];
  logic [31:0] mem_addr_w[3];
  logic        exec_op_w[3];
  logic [6:0]  op_w[3];
  logic [2:0]  f3_w[3];
  logic [6:0]  f7_w[3];
  logic [4:0]  rs1_w[3], rs2_w[3], rd_w[3];
  logic [31:0] pc_o[3];
  logic        retire_w[3];
  logic [31:0] instret_w[3];
  logic        fault_w[3];
  logic [1:0]  fcode_w[3];
  logic [31:0] fpc_w[3];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instret;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ins_fetch_dec #(
      .RESET_PC (g == 2 ? 32'hFFFF_FFFC : 32'h0),
      .TIMEOUT  (g == 0 ? 16 : (g == 1 ? 4 : 0))
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n_v[g]),
      .run            (run),
      .fault_clr      (fault_clr),
      .mem_req        (mem_req_w[g]),
      .mem_addr       (mem_addr_w[g]),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .pc_w_op        (pc_w_op),
      .pc_w_val       (pc_w_val),
      .exec_op        (exec_op_w[g]),
      .ins_dec_op     (op_w[g]),
      .ins_dec_funct3 (f3_w[g]),
      .ins_dec_funct7 (f7_w[g]),
      .reg_rs1        (rs1_w[g]),
      .reg_rs2        (rs2_w[g]),
      .reg_rd         (rd_w[g]),
      .pc             (pc_o[g]),
      .retire         (retire_w[g]),
      .instret        (instret_w[g]),
      .fault          (fault_w[g]),
      .fault_code     (fcode_w[g]),
      .fault_pc       (fpc_w[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds every instance except u in reset; leaves u in IDLE.
  task automatic do_reset(input int u);
    run = 0; fault_clr = 0; mem_ack = 0; pc_w_op = 0;
    mem_rdata = '0; pc_w_val = '0;
    rst_n_v = 3'b000;
    tick(); tick();
    rst_n_v[u] = 1'b1;
    tick();
  endtask

  // Enters with instance u in FETCH; stops in NEXT, or in the following FETCH if expect_fetch.
  task automatic exec_instr(input int u, input logic [31:0] word, input int delay,
                            input bit redir, input logic [31:0] target, input bit expect_fetch);
    logic [31:0] npc;
    logic [31:0] fields;
    checks++; if (mem_req_w[u] !== 1'b1) begin errors++; $display("FAIL fetch_req got %b exp 1", mem_req_w[u]); end
    checks++; if (mem_addr_w[u] !== exp_pc) begin errors++; $display("FAIL fetch_addr got %h exp %h", mem_addr_w[u], exp_pc); end
    for (int i = 0; i < delay; i++) begin
      mem_ack = 0; pc_w_op = 1; pc_w_val = $urandom;
      tick();
      checks++;
      if (mem_req_w[u] !== 1'b1 || mem_addr_w[u] !== exp_pc || fault_w[u] !== 1'b0 || exec_op_w[u] !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold cyc %0d got req %b addr %h fault %b exec %b exp 1 %h 0 0",
                 i, mem_req_w[u], mem_addr_w[u], fault_w[u], exec_op_w[u], exp_pc);
      end
    end
    mem_ack = 1; mem_rdata = word;
    tick();
    mem_ack = 0; mem_rdata = $urandom;
    fields = {f7_w[u], rs2_w[u], rs1_w[u], f3_w[u], rd_w[u], op_w[u]};
    checks++; if (exec_op_w[u] !== 1'b1) begin errors++; $display("FAIL exec_op got %b exp 1", exec_op_w[u]); end
    checks++; if (pc_o[u] !== exp_pc) begin errors++; $display("FAIL exec_pc got %h exp %h", pc_o[u], exp_pc); end
    checks++; if (fields !== word) begin errors++; $display("FAIL fields got %h exp %h", fields, word); end
    checks++; if (mem_req_w[u] !== 1'b0) begin errors++; $display("FAIL exec_req got %b exp 0", mem_req_w[u]); end
    pc_w_op = redir; pc_w_val = target;
    npc = redir ? target : exp_pc + 32'd4;
    tick();
    pc_w_op = 1; pc_w_val = $urandom;
    checks++; if (retire_w[u] !== 1'b1 || exec_op_w[u] !== 1'b0) begin errors++; $display("FAIL next_strobes got retire %b exec %b exp 1 0", retire_w[u], exec_op_w[u]); end
    checks++; if (pc_o[u] !== npc) begin errors++; $display("FAIL next_pc got %h exp %h", pc_o[u], npc); end
    exp_pc = npc;
    exp_instret = exp_instret + 32'd1;
    if (expect_fetch) begin
      tick();
      pc_w_op = 0;
      checks++; if (instret_w[u] !== exp_instret) begin errors++; $display("FAIL instret got %0d exp %0d", instret_w[u], exp_instret); end
      checks++; if (retire_w[u] !== 1'b0) begin errors++; $display("FAIL retire_len got %b exp 0", retire_w[u]); end
    end
  endtask

  task automatic test_reset();
    do_reset(0);
    checks++;
    if (pc_o[0] !== 32'h0 || mem_req_w[0] !== 1'b0 || exec_op_w[0] !== 1'b0 || retire_w[0] !== 1'b0 ||
        fault_w[0] !== 1'b0 || instret_w[0] !== 32'h0 || fcode_w[0] !== 2'd0 || fpc_w[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got pc %h req %b exec %b ret %b flt %b inst %h code %0d fpc %h exp all zero",
               pc_o[0], mem_req_w[0], exec_op_w[0], retire_w[0], fault_w[0], instret_w[0], fcode_w[0], fpc_w[0]);
    end
    checks++; if ({f7_w[0], rs2_w[0], rs1_w[0], f3_w[0], rd_w[0], op_w[0]} !== 32'h0) begin errors++; $display("FAIL reset_fields got nonzero exp 0"); end
    tick();
    checks++; if (mem_req_w[0] !== 1'b0) begin errors++; $display("FAIL idle_no_req got %b exp 0", mem_req_w[0]); end
  endtask

  task automatic test_basic();
    exp_pc = 32'h0; exp_instret = 32'h0;
    run = 1;
    tick();
    exec_instr(0, 32'h002081B3, 0, 0, 32'h0, 1);
    checks++; if (op_w[0] !== 7'h33 || rs1_w[0] !== 5'd1 || rs2_w[0] !== 5'd2 || rd_w[0] !== 5'd3) begin
      errors++; $display("FAIL add_fields got op %h rs1 %0d rs2 %0d rd %0d exp 33 1 2 3", op_w[0], rs1_w[0], rs2_w[0], rd_w[0]);
    end
    checks++; if (mem_addr_w[0] !== 32'h4) begin errors++; $display("FAIL basic_next_addr got %h exp 4", mem_addr_w[0]); end
  endtask

  task automatic test_redirect();
    exec_instr(0, $urandom | 32'h3, 0, 1, 32'h100, 1);
    checks++; if (mem_addr_w[0] !== 32'h100) begin errors++; $display("FAIL redirect_addr got %h exp 100", mem_addr_w[0]); end
  endtask

  task automatic test_delay();
    exec_instr(0, $urandom | 32'h3, 5, 0, 32'h0, 1);
    exec_instr(0, $urandom | 32'h3, 15, 0, 32'h0, 1);
    checks++; if (fault_w[0] !== 1'b0) begin errors++; $display("FAIL delay_no_fault got %b exp 0", fault_w[0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [31:0] w, t;
      w = $urandom | 32'h3;
      t = $urandom & 32'hFFFF_FFFC;
      exec_instr(0, w, $urandom_range(0, 6), ($urandom_range(0, 2) == 0), t, 1);
    end
  endtask

  task automatic test_reset_mid();
    mem_ack = 0;
    tick(); tick();
    rst_n_v[0] = 1'b0;
    #1;
    checks++;
    if (mem_req_w[0] !== 1'b0 || pc_o[0] !== 32'h0 || instret_w[0] !== 32'h0 || exec_op_w[0] !== 1'b0 ||
        retire_w[0] !== 1'b0 || fault_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got req %b pc %h inst %h exec %b ret %b flt %b exp 0 0 0 0 0 0",
               mem_req_w[0], pc_o[0], instret_w[0], exec_op_w[0], retire_w[0], fault_w[0]);
    end
    mem_ack = 1;
    tick();
    mem_ack = 0;
  endtask

  task automatic test_run_low();
    do_reset(0);
    exp_pc = 32'h0; exp_instret = 32'h0;
    run = 1;
    tick();
    exec_instr(0, $urandom | 32'h3, 0, 0, 32'h0, 0);
    run = 0; pc_w_op = 0;
    tick();
    tick();
    checks++; if (mem_req_w[0] !== 1'b0 || pc_o[0] !== exp_pc || instret_w[0] !== exp_instret) begin
      errors++; $display("FAIL run_low got req %b pc %h inst %0d exp 0 %h %0d", mem_req_w[0], pc_o[0], instret_w[0], exp_pc, exp_instret);
    end
    run = 1;
    tick();
    checks++; if (mem_req_w[0] !== 1'b1 || mem_addr_w[0] !== exp_pc) begin
      errors++; $display("FAIL run_resume got req %b addr %h exp 1 %h", mem_req_w[0], mem_addr_w[0], exp_pc);
    end
  endtask

  task automatic test_illegal();
    mem_ack = 1; mem_rdata = 32'h0;
    tick();
    mem_ack = 0; pc_w_op = 1; pc_w_val = 32'h200;
    checks++; if (exec_op_w[0] !== 1'b0) begin errors++; $display("FAIL illegal_exec got %b exp 0", exec_op_w[0]); end
    tick();
    pc_w_op = 0;
    checks++; if (fault_w[0] !== 1'b1 || fcode_w[0] !== 2'd3 || fpc_w[0] !== exp_pc) begin
      errors++; $display("FAIL illegal_fault got %b %0d %h exp 1 3 %h", fault_w[0], fcode_w[0], fpc_w[0], exp_pc);
    end
    checks++; if (exec_op_w[0] !== 1'b0 || instret_w[0] !== exp_instret || mem_req_w[0] !== 1'b0 || pc_o[0] !== exp_pc) begin
      errors++; $display("FAIL illegal_side got exec %b inst %0d req %b pc %h exp 0 %0d 0 %h", exec_op_w[0], instret_w[0], mem_req_w[0], pc_o[0], exp_instret, exp_pc);
    end
    run = 0; fault_clr = 1;
    tick();
    fault_clr = 0;
    checks++; if (fault_w[0] !== 1'b0 || fcode_w[0] !== 2'd0 || fpc_w[0] !== 32'h0 || pc_o[0] !== exp_pc) begin
      errors++; $display("FAIL illegal_clr got %b %0d %h pc %h exp 0 0 0 %h", fault_w[0], fcode_w[0], fpc_w[0], pc_o[0], exp_pc);
    end
  endtask

  task automatic test_misalign();
    run = 1;
    tick();
    exec_instr(0, $urandom | 32'h3, 0, 1, 32'h102, 0);
    pc_w_op = 0;
    tick();
    checks++; if (fault_w[0] !== 1'b1 || fcode_w[0] !== 2'd1 || fpc_w[0] !== 32'h102) begin
      errors++; $display("FAIL misalign_fault got %b %0d %h exp 1 1 102", fault_w[0], fcode_w[0], fpc_w[0]);
    end
    tick();
    checks++; if (mem_req_w[0] !== 1'b0 || instret_w[0] !== exp_instret) begin
      errors++; $display("FAIL misalign_side got req %b inst %0d exp 0 %0d", mem_req_w[0], instret_w[0], exp_instret);
    end
    run = 0; fault_clr = 1;
    tick();
    fault_clr = 0;
    checks++; if (fault_w[0] !== 1'b0 || pc_o[0] !== 32'h102) begin
      errors++; $display("FAIL misalign_clr got %b pc %h exp 0 102", fault_w[0], pc_o[0]);
    end
  endtask

  task automatic test_timeout();
    do_reset(1);
    run = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_req_w[1] !== 1'b1 || fault_w[1] !== 1'b0) begin
        errors++; $display("FAIL timeout_wait cyc %0d got req %b flt %b exp 1 0", i, mem_req_w[1], fault_w[1]);
      end
      tick();
    end
    checks++; if (fault_w[1] !== 1'b1 || fcode_w[1] !== 2'd2 || fpc_w[1] !== 32'h0 || mem_req_w[1] !== 1'b0) begin
      errors++; $display("FAIL timeout_fault got %b %0d %h req %b exp 1 2 0 0", fault_w[1], fcode_w[1], fpc_w[1], mem_req_w[1]);
    end
    run = 0; fault_clr = 1;
    tick();
    fault_clr = 0;
    tick();
    checks++; if (fault_w[1] !== 1'b0 || fcode_w[1] !== 2'd0 || mem_req_w[1] !== 1'b0) begin
      errors++; $display("FAIL timeout_clr got %b %0d req %b exp 0 0 0", fault_w[1], fcode_w[1], mem_req_w[1]);
    end
  endtask

  task automatic test_wrap();
    do_reset(2);
    checks++; if (pc_o[2] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset_pc got %h exp fffffffc", pc_o[2]); end
    exp_pc = 32'hFFFF_FFFC; exp_instret = 32'h0;
    run = 1;
    tick();
    exec_instr(2, $urandom | 32'h3, 20, 0, 32'h0, 1);
    checks++; if (mem_addr_w[2] !== 32'h0 || mem_req_w[2] !== 1'b1) begin
      errors++; $display("FAIL wrap_addr got %h req %b exp 0 1", mem_addr_w[2], mem_req_w[2]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_redirect();
    test_delay();
    test_random();
    test_reset_mid();
    test_run_low();
    test_illegal();
    test_misalign();
    test_timeout();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
